reg_hold_scoreboard: RTL and testbench

- Owns the 16-bit register hold vector (scoreboard) that the operand-read path consumes as hold_Q.
- Arbitrates writebacks from NUM_UNITS functional units onto the single register-file write port.
- Sets a hold bit when an instruction issues with a destination register. Clears it when that register's writeback retires.
- Sits between issue and the register file; the per-register write enables derive from rf_we/rf_waddr.

---
 rtl/reg_hold_scoreboard.sv | 127 ++++++++++++
 tb/tb_reg_hold_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_hold_scoreboard.sv
// Register hold scoreboard with round-robin writeback arbitration.
//
// Tracks one hold bit per architectural register (16). An issued instruction
// sets its destination's hold bit. A granted writeback moves through a
// two-stage write pipeline. W1 registers the rf_* outputs. W2 is the edge
// where the register file captures the write and the hold bit clears.
//
// Optional feature: define SCOREBOARD_ERR_EN to add the sticky sb_err output.
// sb_err flags a write that retires to a register whose hold bit is clear.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   issue_valid  issue presents an instruction with a destination register
//   issue_dest   destination register index
//   issue_ready  combinational; low while the destination is held (WAW stall)
//   wb_valid     per-unit writeback request
//   wb_dest      per-unit destination index, unit k at [4k+3:4k]
//   wb_data      per-unit result, unit k at [DATA_W*k +: DATA_W]
//   wb_grant     combinational one-hot round-robin grant
//   rf_we        registered write enable to the register file
//   rf_waddr     registered write index
//   rf_wdata     registered write data
//   hold_Q       hold vector, bit r set = register r has a pending write
//   sb_err       (SCOREBOARD_ERR_EN only) sticky unheld-write error
module reg_hold_scoreboard #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic [3:0]                    issue_dest,
  output logic                          issue_ready,
  input  logic [NUM_UNITS-1:0]          wb_valid,
  input  logic [4*NUM_UNITS-1:0]        wb_dest,
  input  logic [DATA_W*NUM_UNITS-1:0]   wb_data,
  output logic [NUM_UNITS-1:0]          wb_grant,
  output logic                          rf_we,
  output logic [3:0]                    rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic [15:0]                   hold_Q
`ifdef SCOREBOARD_ERR_EN
  ,
  output logic                          sb_err
`endif
);

  localparam int unsigned PtrW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [15:0]       hold_q, hold_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [3:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              issue_fire;

  assign issue_ready = ~hold_q[issue_dest];
  assign issue_fire  = issue_valid & issue_ready;

  // Round-robin search starting at rr_ptr; the first valid unit wins.
  always_comb begin
    logic        found;
    int unsigned idx;
    found      = 1'b0;
    idx        = 0;
    wb_grant   = '0;
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_UNITS;
      if (!found && wb_valid[idx]) begin
        found         = 1'b1;
        wb_grant[idx] = 1'b1;
        rr_ptr_d      = PtrW'((idx + 1) % NUM_UNITS);
        rf_we_d       = 1'b1;
        rf_waddr_d    = wb_dest[4*idx +: 4];
        rf_wdata_d    = wb_data[DATA_W*idx +: DATA_W];
      end
    end
  end

  // The clear comes from the W1 register, so it coincides with the register-file
  // capture. The set is applied last so that it wins on the same register.
  always_comb begin
    hold_d = hold_q;
    if (rf_we_q) hold_d[rf_waddr_q] = 1'b0;
    if (issue_fire) hold_d[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      hold_q     <= hold_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign hold_Q   = hold_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef SCOREBOARD_ERR_EN
  logic sb_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_q <= 1'b0;
    end else if (rf_we_q && !hold_q[rf_waddr_q]) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;
`endif

endmodule

// File: tb/tb_reg_hold_scoreboard.sv
module tb_reg_hold_scoreboard;

  localparam int unsigned NU = 4;
  localparam int unsigned DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic [3:0]       issue_dest;
  logic             issue_ready;
  logic [NU-1:0]    wb_valid;
  logic [4*NU-1:0]  wb_dest;
  logic [DW*NU-1:0] wb_data;
  logic [NU-1:0]    wb_grant;
  logic             rf_we;
  logic [3:0]       rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic [15:0]      hold_Q;
`ifdef SCOREBOARD_ERR_EN
  logic             sb_err;
`endif

  int checks = 0;
  int failures = 0;

  reg_hold_scoreboard #(.NUM_UNITS(NU), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_dest (issue_dest),
    .issue_ready(issue_ready),
    .wb_valid   (wb_valid),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .wb_grant   (wb_grant),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hold_Q     (hold_Q)
`ifdef SCOREBOARD_ERR_EN
    ,
    .sb_err     (sb_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int k, input logic [3:0] d, input logic [DW-1:0] v);
    wb_valid[k]         = 1'b1;
    wb_dest[4*k +: 4]   = d;
    wb_data[DW*k +: DW] = v;
  endtask

  initial begin
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_dest  = '0;
    wb_valid    = '0;
    wb_dest     = '0;
    wb_data     = '0;
    tick();
    tick();
    chk("rst_hold", 64'(hold_Q), 64'h0);
    chk("rst_we", 64'(rf_we), 64'h0);
    chk("rst_waddr", 64'(rf_waddr), 64'h0);
    chk("rst_wdata", 64'(rf_wdata), 64'h0);
    chk("rst_grant", 64'(wb_grant), 64'h0);
    chk("rst_ready", 64'(issue_ready), 64'h1);
    rst_n = 1'b1;

    // 1: issue 5, writeback from unit 2, two-edge hold clear
    tick();
    issue_valid = 1'b1;
    issue_dest  = 4'd5;
    tick();
    issue_valid = 1'b0;
    chk("t1_hold_set", 64'(hold_Q), 64'h0020);
    set_unit(2, 4'd5, 32'hDEADBEEF);
    #1;
    chk("t1_grant", 64'(wb_grant), 64'b0100);
    tick();
    wb_valid = '0;
    chk("t1_we", 64'(rf_we), 64'h1);
    chk("t1_waddr", 64'(rf_waddr), 64'h5);
    chk("t1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    chk("t1_hold_w1", 64'(hold_Q), 64'h0020);
    tick();
    chk("t1_hold_clr", 64'(hold_Q), 64'h0);
    chk("t1_we_off", 64'(rf_we), 64'h0);
    chk("t1_waddr_keep", 64'(rf_waddr), 64'h5);

    // 2: WAW stall on reg 7 until its writeback retires (rr_ptr=3)
    issue_valid = 1'b1;
    issue_dest  = 4'd7;
    tick();
    chk("t2_hold_set", 64'(hold_Q), 64'h0080);
    #1;
    chk("t2_stall", 64'(issue_ready), 64'h0);
    set_unit(0, 4'd7, 32'h77);
    #1;
    chk("t2_grant", 64'(wb_grant), 64'b0001);
    tick();
    wb_valid = '0;
    chk("t2_hold_kept", 64'(hold_Q), 64'h0080);
    chk("t2_waddr", 64'(rf_waddr), 64'h7);
    chk("t2_stall2", 64'(issue_ready), 64'h0);
    tick();
    chk("t2_hold_clr", 64'(hold_Q), 64'h0);
    chk("t2_ready", 64'(issue_ready), 64'h1);
    issue_valid = 1'b0;

    // Move rr_ptr from 1 to 0 via unit 3; hold reg 1 alongside
    issue_valid = 1'b1;
    issue_dest  = 4'd1;
    set_unit(3, 4'd1, 32'h11);
    #1;
    chk("p3_grant", 64'(wb_grant), 64'b1000);
    tick();
    wb_valid = '0;
    chk("p3_hold", 64'(hold_Q), 64'h0002);
    for (int r = 10; r < 14; r++) begin
      issue_dest = 4'(r);
      tick();
    end
    issue_valid = 1'b0;
    chk("p3_hold_multi", 64'(hold_Q), 64'h3C00);

    // 3: all four units valid from rr_ptr=0
    for (int k = 0; k < 4; k++) set_unit(k, 4'(10 + k), 32'hA0 + 32'(k));
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_grant", 64'(wb_grant), 64'(1) << k);
      tick();
      wb_valid[k] = 1'b0;
      chk("t3_we", 64'(rf_we), 64'h1);
      chk("t3_waddr", 64'(rf_waddr), 64'(10 + k));
      chk("t3_wdata", 64'(rf_wdata), 64'h0A0 + 64'(k));
    end
    chk("t3_hold_partial", 64'(hold_Q), 64'h2000);
    tick();
    chk("t3_we_off", 64'(rf_we), 64'h0);
    chk("t3_hold_clr", 64'(hold_Q), 64'h0);

    // Move rr_ptr from 0 to 2 via unit 1
    issue_valid = 1'b1;
    issue_dest  = 4'd2;
    set_unit(1, 4'd2, 32'h22);
    #1;
    chk("p4_grant", 64'(wb_grant), 64'b0010);
    tick();
    wb_valid    = '0;
    issue_valid = 1'b0;
    tick();
    chk("p4_hold_clr", 64'(hold_Q), 64'h0);

    // 4: units 1 and 3 with rr_ptr=2
    set_unit(1, 4'd6, 32'h66);
    set_unit(3, 4'd8, 32'h88);
    #1;
    chk("t4_grant_u3", 64'(wb_grant), 64'b1000);
    tick();
    wb_valid[3] = 1'b0;
    chk("t4_waddr_u3", 64'(rf_waddr), 64'h8);
    #1;
    chk("t4_grant_u1", 64'(wb_grant), 64'b0010);
    tick();
    chk("t4_waddr_u1", 64'(rf_waddr), 64'h6);
    chk("t4_wdata_u1", 64'(rf_wdata), 64'h66);
    wb_valid[3] = 1'b1;
    #1;
    chk("t4_ptr2", 64'(wb_grant), 64'b1000);
    wb_valid = '0;
    tick();
    tick();

    // 5: issue 3 on the edge where the write to 9 retires
    issue_valid = 1'b1;
    issue_dest  = 4'd9;
    tick();
    issue_valid = 1'b0;
    chk("t5_hold9", 64'(hold_Q), 64'h0200);
    set_unit(0, 4'd9, 32'h99);
    tick();
    wb_valid    = '0;
    issue_valid = 1'b1;
    issue_dest  = 4'd3;
    #1;
    chk("t5_ready", 64'(issue_ready), 64'h1);
    tick();
    issue_valid = 1'b0;
    chk("t5_hold", 64'(hold_Q), 64'h0008);

    // 6: reset during W1 of a write to reg 4
    set_unit(0, 4'd4, 32'h44);
    tick();
    wb_valid = '0;
    chk("t6_we_pre", 64'(rf_we), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_we_rst", 64'(rf_we), 64'h0);
    chk("t6_hold_rst", 64'(hold_Q), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_we_post", 64'(rf_we), 64'h0);
    chk("t6_hold_post", 64'(hold_Q), 64'h0);
`ifdef SCOREBOARD_ERR_EN
    chk("t6_err_rst", 64'(sb_err), 64'h0);
    set_unit(0, 4'd12, 32'hCC);
    tick();
    wb_valid = '0;
    chk("t6_err_w1", 64'(sb_err), 64'h0);
    tick();
    chk("t6_err_set", 64'(sb_err), 64'h1);
    tick();
    tick();
    chk("t6_err_sticky", 64'(sb_err), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
